// File: rtl/clk_monitor.sv
// Clock monitor: measures period and high time of asynchronous mon_clk in clk cycles,
// flags out-of-range periods and a dead clock. Optional duty check: DUTY_CHECK_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | en=0, counters cleared, outputs hold
// S_WAIT_RISE | discard partial mon_clk cycle, wait for first rise
// S_MEAS_HIGH | counting period and high time, waiting for fall
// S_MEAS_LOW  | counting period, waiting for rise to close the measurement
module clk_monitor #(
   parameter int CNT_W      = 16,
   parameter int EXP_PERIOD = 10,
   parameter int TOL        = 1,
   parameter int TIMEOUT    = 1024
`ifdef DUTY_CHECK_EN
   ,
   parameter int EXP_HIGH   = 6
`endif
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mon_clk,
   input  logic             en,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             meas_valid,
   output logic             in_range,
   output logic             no_clk,
   output logic [7:0]       err_cnt
`ifdef DUTY_CHECK_EN
   ,
   output logic             duty_ok
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_RISE, S_MEAS_HIGH, S_MEAS_LOW} state_t;

   localparam int             TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0]  TO_MAX  = TW'(TIMEOUT);
   // Bounds carry one extra bit so a tolerance wider than the target cannot wrap.
   localparam logic [CNT_W:0] PRD_LO  = (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
   localparam logic [CNT_W:0] PRD_HI  = (CNT_W+1)'(EXP_PERIOD + TOL);

   state_t           r_state;
   logic             r_sync1, r_sync2, r_sync3;
   logic [CNT_W-1:0] r_pcnt, r_hcnt, r_period, r_high_time;
   logic [TW-1:0]    r_tcnt;
   logic             r_meas_valid, r_in_range, r_no_clk;
   logic [7:0]       r_err_cnt;
   logic             w_rise, w_fall, w_timeout, w_prd_ok, w_meas_err;

   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   assign w_rise    = r_sync2 & ~r_sync3;
   assign w_fall    = ~r_sync2 & r_sync3;
   assign w_timeout = en & ~(w_rise | w_fall) & (r_tcnt == TO_LAST);
   assign w_prd_ok  = ({1'b0, r_pcnt} >= PRD_LO) && ({1'b0, r_pcnt} <= PRD_HI) && !(&r_pcnt);

`ifdef DUTY_CHECK_EN
   localparam logic [CNT_W:0] DTY_LO = (EXP_HIGH > TOL) ? (CNT_W+1)'(EXP_HIGH - TOL) : '0;
   localparam logic [CNT_W:0] DTY_HI = (CNT_W+1)'(EXP_HIGH + TOL);
   logic w_duty_ok, r_duty_ok;
   assign w_duty_ok  = ({1'b0, r_high_time} >= DTY_LO) && ({1'b0, r_high_time} <= DTY_HI);
   assign w_meas_err = !w_prd_ok || !w_duty_ok;
   assign duty_ok    = r_duty_ok;
`else
   assign w_meas_err = !w_prd_ok;
`endif

   assign period     = r_period;
   assign high_time  = r_high_time;
   assign meas_valid = r_meas_valid;
   assign in_range   = r_in_range;
   assign no_clk     = r_no_clk;
   assign err_cnt    = r_err_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= mon_clk;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt   <= '0;
         r_no_clk <= 1'b0;
      end else begin
         if (!en || w_rise || w_fall)
            r_tcnt <= '0;
         else if (r_tcnt != TO_MAX)
            r_tcnt <= r_tcnt + TW'(1);
         if (w_timeout)
            r_no_clk <= 1'b1;
         else if (en && w_rise)
            r_no_clk <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_pcnt       <= '0;
         r_hcnt       <= '0;
         r_period     <= '0;
         r_high_time  <= '0;
         r_meas_valid <= 1'b0;
         r_in_range   <= 1'b0;
         r_err_cnt    <= '0;
`ifdef DUTY_CHECK_EN
         r_duty_ok    <= 1'b0;
`endif
      end else begin
         r_meas_valid <= 1'b0;
         if (!en) begin
            r_state <= S_IDLE;
            r_pcnt  <= '0;
            r_hcnt  <= '0;
         end else if (w_timeout) begin
            r_state <= S_WAIT_RISE;
            r_pcnt  <= '0;
            r_hcnt  <= '0;
         end else begin
            case (r_state)
               S_IDLE: r_state <= S_WAIT_RISE;
               S_WAIT_RISE: begin
                  if (w_rise) begin
                     r_pcnt  <= CNT_W'(1);
                     r_hcnt  <= CNT_W'(1);
                     r_state <= S_MEAS_HIGH;
                  end
               end
               S_MEAS_HIGH: begin
                  r_pcnt <= f_sat_inc(r_pcnt);
                  r_hcnt <= f_sat_inc(r_hcnt);
                  if (w_fall) begin
                     r_high_time <= r_hcnt;
                     r_state     <= S_MEAS_LOW;
                  end
               end
               S_MEAS_LOW: begin
                  if (w_rise) begin
                     r_period     <= r_pcnt;
                     r_meas_valid <= 1'b1;
                     r_in_range   <= w_prd_ok;
`ifdef DUTY_CHECK_EN
                     r_duty_ok    <= w_duty_ok;
`endif
                     if (w_meas_err && r_err_cnt != 8'hFF)
                        r_err_cnt <= r_err_cnt + 8'd1;
                     r_pcnt  <= CNT_W'(1);
                     r_hcnt  <= CNT_W'(1);
                     r_state <= S_MEAS_HIGH;
                  end else begin
                     r_pcnt <= f_sat_inc(r_pcnt);
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
Receiving end of the team's clock generators. It measures an incoming, asynchronous clock `mon_clk` in units of the system clock `clk`.
- Reports period and high time for every mon_clk cycle.
- Flags period out of tolerance.
- Detects a dead or stopped clock.

It sits beside generated or external clocks in self-checking benches and on silicon as a clock-health monitor.

Parameters:
- CNT_W, 16, width of period/high-time counters and outputs.
- EXP_PERIOD, 10, expected mon_clk period in clk cycles.
- TOL, 1, allowed absolute deviation from EXP_PERIOD in clk cycles.
- TIMEOUT, 1024, clk cycles without any mon_clk edge before no_clk asserts.
- EXP_HIGH, 6, expected high time in clk cycles (used only with DUTY_CHECK_EN).

Ports:
- clk  input  1  system/measurement clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mon_clk  input  1  monitored clock, asynchronous to clk.
- en  input  1  measurement enable.
- period  output  CNT_W  last measured period (clk cycles, rise to rise).
- high_time  output  CNT_W  last measured high time (clk cycles, rise to fall).
- meas_valid  output  1  one-cycle pulse when period/high_time/in_range update.
- in_range  output  1  1 when the last period is within EXP_PERIOD±TOL.
- no_clk  output  1  level; 1 while mon_clk is considered dead.
- err_cnt  output  8  count of out-of-range measurements, saturating at 255.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, synchronizer flops 0, counters 0, state IDLE.
- mon_clk passes through a 2-flop synchronizer, then a third flop for edge detect. rise/fall pulses are single clk cycles, 3 cycles after the pin transition. This latency is constant, so it does not bias measurements.
- States:
  - IDLE: en=0. Counters held at 0. Outputs hold their last values. meas_valid=0. en=1 goes to WAIT_RISE.
  - WAIT_RISE: discard partial cycle. On rise: pcnt=1, hcnt=1, go to MEAS_HIGH.
  - MEAS_HIGH: pcnt and hcnt increment each cycle. On fall: latch hcnt into high_time, go to MEAS_LOW.
  - MEAS_LOW: pcnt increments. On rise:
    - latch period=pcnt, pulse meas_valid.
    - update in_range.
    - if out of range, err_cnt+1 (saturating).
    - reload pcnt=1, hcnt=1, return to MEAS_HIGH (back-to-back measurement, no gap).
- Resulting counts: period counts clk cycles between consecutive detected rises. Example: 100 MHz clk, 10 MHz mon_clk at 60% duty gives period=10, high_time=6.
- First measurement after leaving WAIT_RISE needs one full mon_clk cycle. No meas_valid for the partial cycle.
- Counters saturate at 2^CNT_W-1 and never wrap. A saturated period is reported as-is, with in_range=0.
- in_range = (period >= EXP_PERIOD-TOL) && (period <= EXP_PERIOD+TOL). Compare in CNT_W+1 bits so EXP_PERIOD<TOL cannot underflow.
- Timeout counter:
  - Clears on any rise or fall edge. Increments otherwise while en=1.
  - On reaching TIMEOUT: no_clk=1, state goes to WAIT_RISE, no meas_valid.
  - no_clk clears on the next detected rise.
  - period/high_time keep stale values while no_clk=1.
- en deasserted mid-measurement: go to IDLE next cycle. Partial counts are discarded, no meas_valid, no_clk holds its value.
- en and rise in the same cycle: en=0 wins.
- rst_n asserted mid-measurement: immediate return to reset values, including err_cnt.
- mon_clk faster than clk/4 is unsupported. Edges may be missed and results are undefined, but the block must not hang and the timeout keeps working.

Optional Feature:
- Macro DUTY_CHECK_EN.
- Defined: adds output port duty_ok (1 bit, reset 0). It updates with meas_valid and is 1 when |high_time-EXP_HIGH| <= TOL. A duty failure also increments err_cnt (once per measurement, even if both checks fail).
- Undefined: no duty_ok port, EXP_HIGH unused, err_cnt counts period failures only.

Test Plan:
- Nominal, clk 10 ns, en=1, mon_clk 100 ns at 60% duty for 5 cycles → 4 meas_valid pulses, each with period=10, high_time=6, in_range=1, err_cnt=0, no_clk=0.
- Off-frequency, mon_clk 120 ns at 50% duty → period=12, high_time=6, in_range=0, err_cnt increments per pulse; 300 pulses → err_cnt=255 (saturates).
- Dead clock, mon_clk stops low after 3 cycles → no_clk=1 exactly TIMEOUT (1024) cycles after the last detected fall; after restart, no_clk=0 at the first rise and first meas_valid one period later.
- Enable and reset, en dropped mid high phase → no meas_valid, outputs hold; rst_n pulsed low for 3 ns asynchronously → all outputs 0 immediately.
- Duty check with DUTY_CHECK_EN, mon_clk 100 ns at 80% duty → period=10, high_time=8, in_range=1, duty_ok=0, err_cnt+1 per pulse.
